semaforo_monitor: RTL and testbench



---
 rtl/semaforo_monitor.sv | 143 ++++++++++++++
 tb/tb_semaforo_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor.sv
// Passive checker for the two semaforo light buses: encoding, conflict, phase order and durations.
// Optional build macro SEMAFORO_MON_STICKY_EN makes err sticky until rst; otherwise err pulses per violation.
module semaforo_monitor #(
  parameter logic [7:0] GREEN_MAX  = 8'd3,
  parameter logic [7:0] YELLOW_CYC = 8'd1,
  parameter logic [7:0] RED_MAX    = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] a_cycles,
  output logic [7:0]  a_dur
);

  typedef enum logic [1:0] {SYNC, GRN, YEL, RED} st_t;

  typedef struct packed {
    st_t        st;
    logic [7:0] dur;
    logic       first;
    logic       enc;
    logic       trn;
    logic       dur_err;
  } trk_t;

  // Next-state and violation flags of one light tracker for one sample.
  function automatic trk_t f_trk(input st_t st, input logic [7:0] dur,
                                 input logic first, input logic [2:0] c);
    trk_t       r;
    st_t        col;
    logic [7:0] lim;
    r.st      = st;
    r.dur     = dur;
    r.first   = first;
    r.enc     = 1'b0;
    r.trn     = 1'b0;
    r.dur_err = 1'b0;
    col = (c == 3'b001) ? GRN : (c == 3'b010) ? YEL : RED;
    lim = (col == GRN) ? GREEN_MAX : (col == YEL) ? YELLOW_CYC : RED_MAX;
    if (!$onehot(c)) begin
      r.enc   = 1'b1;
      r.st    = SYNC;
      r.dur   = 8'd0;
      r.first = 1'b0;
    end else if (st == SYNC) begin
      // First phase after SYNC is partial: only the maximum applies.
      r.st      = col;
      r.dur     = 8'd1;
      r.first   = 1'b1;
      r.dur_err = (8'd1 > lim);
    end else if (col == st) begin
      r.dur     = (dur == 8'hFF) ? dur : dur + 8'd1;
      r.dur_err = (r.dur > lim) && (dur <= lim);
    end else begin
      r.trn     = !((st == GRN && col == YEL) || (st == YEL && col == RED) ||
                    (st == RED && col == GRN));
      r.dur_err = (st == YEL && !first && dur < YELLOW_CYC) || (8'd1 > lim);
      r.st      = col;
      r.dur     = 8'd1;
      r.first   = 1'b0;
    end
    return r;
  endfunction

  st_t         r_a_st, r_b_st;
  logic [7:0]  r_a_dur, r_b_dur;
  logic        r_a_first, r_b_first;
  logic        r_a_chain;
  logic [15:0] r_a_cycles;
  logic        r_err;
  logic [2:0]  r_err_code;

  trk_t        w_a, w_b;
  logic        w_conf;
  logic        w_a_legal;
  logic [2:0]  w_code;

  assign w_a    = f_trk(r_a_st, r_a_dur, r_a_first, A);
  assign w_b    = f_trk(r_b_st, r_b_dur, r_b_first, B);
  assign w_conf = $onehot(A) && $onehot(B) && !A[2] && !B[2];
  assign w_a_legal = (r_a_st != SYNC) && !w_a.enc && (w_a.st != r_a_st) && !w_a.trn;

  always_comb begin
    w_code = 3'd0;
    if      (w_a.enc)     w_code = 3'd1;
    else if (w_b.enc)     w_code = 3'd2;
    else if (w_conf)      w_code = 3'd3;
    else if (w_a.trn)     w_code = 3'd4;
    else if (w_b.trn)     w_code = 3'd5;
    else if (w_a.dur_err) w_code = 3'd6;
    else if (w_b.dur_err) w_code = 3'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_st     <= SYNC;
      r_b_st     <= SYNC;
      r_a_dur    <= 8'd0;
      r_b_dur    <= 8'd0;
      r_a_first  <= 1'b0;
      r_b_first  <= 1'b0;
      r_a_chain  <= 1'b0;
      r_a_cycles <= 16'd0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
    end else begin
      r_a_st    <= w_a.st;
      r_b_st    <= w_b.st;
      r_a_dur   <= w_a.dur;
      r_b_dur   <= w_b.dur;
      r_a_first <= w_a.first;
      r_b_first <= w_b.first;
      // chain: the current A phase belongs to a cycle whose phases were all entered legally
      if (w_a.enc) begin
        r_a_chain <= 1'b0;
      end else if (r_a_st == SYNC) begin
        r_a_chain <= (w_a.st == GRN);
      end else if (w_a.st != r_a_st) begin
        if (w_a_legal) begin
          if (r_a_st == RED && r_a_chain) r_a_cycles <= r_a_cycles + 16'd1;
          if (w_a.st == GRN) r_a_chain <= 1'b1;
        end else begin
          r_a_chain <= 1'b0;
        end
      end
      if (r_err_code == 3'd0) r_err_code <= w_code;
`ifdef SEMAFORO_MON_STICKY_EN
      r_err <= r_err | (w_code != 3'd0);
`else
      r_err <= (w_code != 3'd0);
`endif
    end
  end

  assign err      = r_err;
  assign err_code = r_err_code;
  assign a_cycles = r_a_cycles;
  assign a_dur    = r_a_dur;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: a behavioural model pushes expected outputs per sample.
module tb_semaforo_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] a_cycles;
  logic [7:0]  a_dur;

  localparam int GMAX = 3, YEL = 1, RMAX = 6;

  semaforo_monitor dut (
    .clk(clk), .rst(rst), .A(A), .B(B),
    .err(err), .err_code(err_code), .a_cycles(a_cycles), .a_dur(a_dur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [2:0]  code;
    logic [15:0] cyc;
    logic [7:0]  dur;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   err_hi = 0;

  int   m_st[2];
  int   m_dur[2];
  bit   m_first[2];
  bit   m_legal[2];
  bit   m_chain;
  int   m_cyc;
  bit   m_err;
  int   m_code;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lim(input int col);
    return (col == 1) ? GMAX : (col == 2) ? YEL : RMAX;
  endfunction

  // Colour codes in the model: 0 sync, 1 green, 2 yellow, 3 red.
  task automatic mdl_trk(input int i, input logic [2:0] c,
                         output bit enc, output bit trn, output bit dr);
    int col;
    int prev;
    col  = (c == 3'b001) ? 1 : (c == 3'b010) ? 2 : (c == 3'b100) ? 3 : 0;
    prev = m_st[i];
    enc = 0; trn = 0; dr = 0; m_legal[i] = 0;
    if (col == 0) begin
      enc = 1; m_st[i] = 0; m_dur[i] = 0;
    end else if (prev == 0) begin
      m_st[i] = col; m_dur[i] = 1; m_first[i] = 1; dr = (1 > lim(col));
    end else if (col == prev) begin
      if (m_dur[i] < 255) m_dur[i]++;
      dr = (m_dur[i] == lim(col) + 1);
    end else begin
      m_legal[i] = (col == prev % 3 + 1);
      trn = !m_legal[i];
      dr = (prev == 2 && !m_first[i] && m_dur[i] < YEL) || (1 > lim(col));
      m_st[i] = col; m_dur[i] = 1; m_first[i] = 0;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    bit ae, at, ad, be, bt, bd, conf;
    int code, pa;
    rst = r; A = a; B = b;
    if (r) begin
      m_st = '{0, 0}; m_dur = '{0, 0}; m_first = '{0, 0};
      m_chain = 0; m_cyc = 0; m_err = 0; m_code = 0;
    end else begin
      pa = m_st[0];
      mdl_trk(0, a, ae, at, ad);
      mdl_trk(1, b, be, bt, bd);
      if (ae) m_chain = 0;
      else if (pa == 0) m_chain = (m_st[0] == 1);
      else if (m_st[0] != pa) begin
        if (m_legal[0]) begin
          if (pa == 3 && m_chain) m_cyc = (m_cyc + 1) & 16'hFFFF;
          if (m_st[0] == 1) m_chain = 1;
        end else m_chain = 0;
      end
      conf = !ae && !be && !a[2] && !b[2];
      code = ae ? 1 : be ? 2 : conf ? 3 : at ? 4 : bt ? 5 : ad ? 6 : bd ? 7 : 0;
      if (m_code == 0) m_code = code;
`ifdef SEMAFORO_MON_STICKY_EN
      m_err = m_err || (code != 0);
`else
      m_err = (code != 0);
`endif
    end
    e.err = m_err; e.code = 3'(m_code); e.cyc = 16'(m_cyc); e.dur = 8'(m_dur[0]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("err", 32'(err), 32'(e.err));
    chk("err_code", 32'(err_code), 32'(e.code));
    chk("a_cycles", 32'(a_cycles), 32'(e.cyc));
    chk("a_dur", 32'(a_dur), 32'(e.dur));
    if (err === 1'b1) err_hi++;
  endtask

  // Legal schedule, period 10: A G3 Y1 R6; B red except G3 Y1 while A is red.
  task automatic legal_step(input int t);
    logic [2:0] a, b;
    a = (t < 3) ? 3'b001 : (t == 3) ? 3'b010 : 3'b100;
    b = (t >= 4 && t <= 6) ? 3'b001 : (t == 7) ? 3'b010 : 3'b100;
    step(1'b0, a, b);
  endtask

  initial begin
    rst = 1'b1; A = 3'b000; B = 3'b000;

    step(1'b1, 3'b000, 3'b000);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_cyc", 32'(a_cycles), 32'd0);
    chk("rst_dur", 32'(a_dur), 32'd0);

    for (int t = 0; t < 11; t++) legal_step(t % 10);
    chk("legal_code", 32'(err_code), 32'd0);
    chk("legal_cyc", 32'(a_cycles), 32'd1);

    for (int k = 0; k < 3; k++) step(1'b0, 3'b001, 3'b100);
    chk("green_long_code", 32'(err_code), 32'd6);
    chk("green_long_dur", 32'(a_dur), 32'd4);
    chk("green_long_err", 32'(err), 32'd1);

    step(1'b1, 3'b001, 3'b100);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_code", 32'(err_code), 32'd0);
    chk("midrst_cyc", 32'(a_cycles), 32'd0);
    chk("midrst_dur", 32'(a_dur), 32'd0);
    step(1'b0, 3'b001, 3'b100);
    chk("resync_err", 32'(err), 32'd0);
    chk("resync_code", 32'(err_code), 32'd0);
    chk("resync_dur", 32'(a_dur), 32'd1);

    step(1'b1, 3'b000, 3'b000);
    err_hi = 0;
    for (int k = 0; k < 5; k++) step(1'b0, 3'b001, 3'b100);
    step(1'b0, 3'b010, 3'b100);
    for (int k = 0; k < 4; k++) step(1'b0, 3'b100, 3'b001);
`ifdef SEMAFORO_MON_STICKY_EN
    chk("err_high_cycles", 32'(err_hi), 32'd7);
`else
    chk("err_high_cycles", 32'(err_hi), 32'd2);
`endif
    chk("two_dur_code", 32'(err_code), 32'd6);

    step(1'b1, 3'b000, 3'b000);
    step(1'b0, 3'b001, 3'b001);
    chk("conflict_code", 32'(err_code), 32'd3);
    step(1'b1, 3'b000, 3'b000);
    step(1'b0, 3'b011, 3'b001);
    chk("enc_beats_conflict", 32'(err_code), 32'd1);

    step(1'b1, 3'b000, 3'b000);
    step(1'b0, 3'b001, 3'b100);
    step(1'b0, 3'b100, 3'b100);
    chk("jump_code", 32'(err_code), 32'd4);
    chk("jump_dur", 32'(a_dur), 32'd1);

    step(1'b1, 3'b000, 3'b000);
    step(1'b0, 3'b100, 3'b000);
    chk("b_enc_code", 32'(err_code), 32'd2);

    step(1'b1, 3'b000, 3'b000);
    for (int k = 0; k < 260; k++) step(1'b0, 3'b100, 3'b100);
    chk("dur_sat", 32'(a_dur), 32'd255);
    chk("sat_code", 32'(err_code), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
